// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings and types for the multi-cycle CPU datapath
package cpu_pkg;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;
  localparam logic [1:0] COND_EQ = 2'b00;
  localparam logic [1:0] COND_NE = 2'b01;
  localparam logic [1:0] COND_LT = 2'b10;
  localparam logic [1:0] COND_LE = 2'b11;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic {FETCH_IDLE, FETCH_BUSY} fetch_state_e;
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
    return {pc[31:28], instr[25:0], 2'b00};
  endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: decodes the branch condition select against the ALU flags
module branch_cond
  import cpu_pkg::*;
(
  input  logic [1:0] BorN,
  input  logic       Zero,
  input  logic       Neg,
  output logic       take
);
  always_comb
    take = BorN == COND_EQ ? Zero :
           BorN == COND_NE ? !Zero :
           BorN == COND_LT ? Neg : (Neg | Zero);
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC and IR with ready-handshaked instruction fetch; FETCH_TIMEOUT_EN adds a fetch timeout and sticky FetchErr
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic [1:0]        PCSource,
  input  logic [1:0]        BorN,
  input  logic              IRWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       ALUOut,
  input  logic              Zero,
  input  logic              Neg,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instr,
  output logic [5:0]        Opcode,
  output logic              Stall,
  output logic              FetchErr
);
  if (MAX_WAIT < 1) begin : g_max_wait_check
    $error("MAX_WAIT must be at least 1");
  end
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, pc_src;
  logic [31:0] ir_q, ir_d;
  fetch_state_e state_q, state_d;
  logic take;
  branch_cond u_cond (.BorN(BorN), .Zero(Zero), .Neg(Neg), .take(take));
  always_comb begin
    pc_src = PCSource == PCSRC_ALU    ? ALUResult[ADDR_W-1:0] :
             PCSource == PCSRC_ALUOUT ? ALUOut[ADDR_W-1:0] :
             PCSource == PCSRC_JUMP   ? ADDR_W'(jump_target(32'(pc_q), ir_q)) : pc_q;
    pc_d = (PCWrite | (PCWriteCond & take)) ? pc_src : pc_q;
  end
`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic err_q, err_d, timeout;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
    timeout = state_q == FETCH_BUSY && !imem_ready && wait_q == WAIT_W'(MAX_WAIT - 1);
`endif
    if (state_q == FETCH_IDLE) begin
      if (IRWrite) begin
        state_d = FETCH_BUSY;
        addr_d  = pc_q;
`ifdef FETCH_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
    end else if (imem_ready) begin
      state_d = FETCH_IDLE;
      ir_d    = imem_rdata;
    end
`ifdef FETCH_TIMEOUT_EN
    else if (timeout) begin
      state_d = FETCH_IDLE;
      ir_d    = NOP_INSTR;
      err_d   = 1'b1;
    end else
      wait_d = wait_q + 1'b1;
`endif
  end
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      state_q <= FETCH_IDLE;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      state_q <= state_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  assign imem_req  = state_q == FETCH_BUSY;
  assign Stall     = state_q == FETCH_BUSY;
  assign imem_addr = addr_q;
  assign Instr     = ir_q;
  assign Opcode    = ir_q[31:26];
`ifdef FETCH_TIMEOUT_EN
  assign FetchErr  = err_q;
`else
  assign FetchErr  = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: randomized and directed checks of fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;
  localparam int MAX_WAIT = 15;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic CLK, Reset, PCWrite, PCWriteCond, IRWrite, Zero, Neg, imem_ready;
  logic [1:0] PCSource, BorN;
  logic [31:0] ALUResult, ALUOut, imem_rdata, imem_addr, Instr;
  logic imem_req, Stall, FetchErr;
  logic [5:0] Opcode;
  int total, bad;
  logic [31:0] m_pc, m_ir, m_addr;
  bit m_busy, m_err;
  int m_wait;

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .BorN(BorN), .IRWrite(IRWrite), .ALUResult(ALUResult),
    .ALUOut(ALUOut), .Zero(Zero), .Neg(Neg), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instr(Instr), .Opcode(Opcode),
    .Stall(Stall), .FetchErr(FetchErr));

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_reset();
    m_pc = RESET_PC; m_ir = 0; m_addr = RESET_PC; m_busy = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic idle_inputs();
    PCWrite = 0; PCWriteCond = 0; PCSource = 0; BorN = 0; IRWrite = 0;
    ALUResult = 0; ALUOut = 0; Zero = 0; Neg = 0; imem_ready = 0; imem_rdata = 0;
  endtask

  // advance one clock and update the model from the inputs seen at that edge
  task automatic step();
    bit cond[4];
    logic [31:0] tgt[4];
    logic [31:0] n_pc;
    cond = '{Zero, !Zero, Neg, Neg | Zero};
    tgt = '{ALUResult, ALUOut, {m_pc[31:28], m_ir[25:0], 2'b00}, m_pc};
    n_pc = (PCWrite || (PCWriteCond && cond[BorN])) ? tgt[PCSource] : m_pc;
    @(posedge CLK);
    if (Reset) begin
      if (!m_busy) begin
        if (IRWrite) begin m_busy = 1; m_addr = m_pc; m_wait = 0; end
      end else if (imem_ready) begin
        m_ir = imem_rdata; m_busy = 0;
      end else begin
        m_wait++;
`ifdef FETCH_TIMEOUT_EN
        if (m_wait == MAX_WAIT) begin m_busy = 0; m_ir = 0; m_err = 1; end
`endif
      end
      m_pc = n_pc;
    end
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    PCWrite = 1; PCSource = 2'b00; ALUResult = v;
    step();
    PCWrite = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 Reset = 1;
    total++; if (dut.pc_q !== RESET_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", dut.pc_q, RESET_PC); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (Instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", Instr); end
    total++; if (Stall !== 1'b0 || FetchErr !== 1'b0) begin bad++; $display("FAIL reset_flags: stall=%b err=%b want 0 0", Stall, FetchErr); end
  endtask

  task automatic test_first_fetch();
    IRWrite = 1; PCWrite = 1; PCSource = 2'b00; ALUResult = 32'h4;
    step();
    IRWrite = 0; PCWrite = 0;
    total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL first_addr: addr=%h req=%b want 0 1", imem_addr, imem_req); end
    total++; if (dut.pc_q !== 32'h4) begin bad++; $display("FAIL first_pc: got %h want 4", dut.pc_q); end
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL first_stall: got %b want 1", Stall); end
    imem_ready = 1; imem_rdata = 32'h3C01_0005;
    step();
    imem_ready = 0;
    total++; if (Opcode !== 6'h0F || Instr !== 32'h3C01_0005) begin bad++; $display("FAIL first_opcode: op=%h ir=%h want 0f 3c010005", Opcode, Instr); end
    total++; if (Stall !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL first_done: stall=%b req=%b want 0 0", Stall, imem_req); end
  endtask

  task automatic test_back_to_back();
    int stalls = 0, rises = 0;
    logic prev = 0;
    IRWrite = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (Stall === 1'b1) stalls++;
      if (imem_req === 1'b1 && !prev) rises++;
      prev = imem_req;
      IRWrite = (i == 1);
      imem_ready = (i == 3);
      imem_rdata = 32'h1234_5678;
    end
    imem_ready = 0; IRWrite = 0;
    total++; if (stalls != 4) begin bad++; $display("FAIL wait_stall_cycles: got %0d want 4", stalls); end
    total++; if (rises != 1) begin bad++; $display("FAIL wait_requests: got %0d want 1", rises); end
    total++; if (Instr !== 32'h1234_5678) begin bad++; $display("FAIL wait_instr: got %h want 12345678", Instr); end
  endtask

  task automatic test_branch();
    logic [1:0] bn[3] = '{2'b00, 2'b01, 2'b11};
    logic [31:0] exp[3] = '{32'h40, 32'h100, 32'h40};
    for (int i = 0; i < 3; i++) begin
      set_pc(32'h100);
      PCWriteCond = 1; PCSource = 2'b01; ALUOut = 32'h40; BorN = bn[i]; Zero = 1; Neg = 0;
      step();
      PCWriteCond = 0; Zero = 0;
      total++; if (dut.pc_q !== exp[i] || m_pc !== exp[i]) begin bad++; $display("FAIL branch_%0d: got %h model %h want %h", i, dut.pc_q, m_pc, exp[i]); end
    end
  endtask

  task automatic test_jump();
    set_pc(32'hA000_0010);
    IRWrite = 1;
    step();
    IRWrite = 0; imem_ready = 1; imem_rdata = 32'h0800_0100;
    step();
    imem_ready = 0;
    PCWrite = 1; PCSource = 2'b10;
    step();
    PCWrite = 0;
    total++; if (dut.pc_q !== 32'hA000_0400) begin bad++; $display("FAIL jump_pc: got %h want a0000400", dut.pc_q); end
  endtask

  task automatic test_timeout();
    int n = 0;
    IRWrite = 1; imem_ready = 0;
    step();
    IRWrite = 0;
    while (imem_req === 1'b1 && n < 40) begin n++; step(); end
`ifdef FETCH_TIMEOUT_EN
    total++; if (n != MAX_WAIT) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, MAX_WAIT); end
    total++; if (Instr !== 32'h0 || FetchErr !== 1'b1) begin bad++; $display("FAIL timeout_state: ir=%h err=%b want 0 1", Instr, FetchErr); end
    IRWrite = 1;
    step();
    IRWrite = 0; imem_ready = 1; imem_rdata = 32'h2000_0001;
    step();
    imem_ready = 0;
    total++; if (FetchErr !== 1'b1 || Instr !== 32'h2000_0001) begin bad++; $display("FAIL timeout_sticky: err=%b ir=%h want 1 20000001", FetchErr, Instr); end
`else
    total++; if (n != 40 || Stall !== 1'b1) begin bad++; $display("FAIL nowait_limit: cycles=%0d stall=%b want 40 1", n, Stall); end
    total++; if (FetchErr !== 1'b0) begin bad++; $display("FAIL nowait_err: got %b want 0", FetchErr); end
    imem_ready = 1; imem_rdata = 32'h2000_0001;
    step();
    imem_ready = 0;
    total++; if (Stall !== 1'b0 || Instr !== 32'h2000_0001) begin bad++; $display("FAIL nowait_done: stall=%b ir=%h want 0 20000001", Stall, Instr); end
`endif
  endtask

  task automatic test_reset_mid();
    set_pc(32'h1234);
    IRWrite = 1;
    step();
    IRWrite = 0;
    step();
    Reset = 0;
    model_reset();
    #1;
    total++; if (imem_req !== 1'b0 || Stall !== 1'b0) begin bad++; $display("FAIL midreset_req: req=%b stall=%b want 0 0", imem_req, Stall); end
    total++; if (dut.pc_q !== RESET_PC || Instr !== 32'h0) begin bad++; $display("FAIL midreset_state: pc=%h ir=%h want %h 0", dut.pc_q, Instr, RESET_PC); end
    @(posedge CLK);
    #1 Reset = 1;
    imem_ready = 1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ready = 0;
    total++; if (Instr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL midreset_late_data: ir=%h req=%b want 0 0", Instr, imem_req); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      IRWrite = ($urandom % 3) == 0;
      PCWrite = ($urandom % 4) == 0;
      PCWriteCond = ($urandom % 3) == 0;
      PCSource = 2'($urandom);
      BorN = 2'($urandom);
      ALUResult = $urandom; ALUOut = $urandom;
      Zero = 1'($urandom); Neg = 1'($urandom);
      imem_ready = 1'($urandom); imem_rdata = $urandom;
      step();
      total++;
      if (dut.pc_q !== m_pc || imem_req !== m_busy || Stall !== m_busy || Instr !== m_ir ||
          FetchErr !== m_err || (m_busy && imem_addr !== m_addr)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL random_%0d: pc=%h/%h busy=%b/%b ir=%h/%h addr=%h/%h err=%b/%b",
          i, dut.pc_q, m_pc, imem_req, m_busy, Instr, m_ir, imem_addr, m_addr, FetchErr, m_err);
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_branch();
    test_jump();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
